// File: rtl/mmcm_reset_supervisor.sv
// MMCM reset/lock supervisor: pulses MMCM RST, waits for a stable LOCKED, retries on timeout.
// Optional LOCK_LOSS_CNT output is compiled in when LOCK_LOSS_CNT_EN is defined.
module mmcm_reset_supervisor #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 4096,
  parameter int STABLE_CYCLES       = 256,
  parameter int MAX_RETRIES         = 7
) (
  input  logic       CLKIN1,
  input  logic       RST_N,
  input  logic       LOCKED,
  input  logic       FORCE_RESET,
  output logic       MMCM_RST,
  output logic       SYS_RST_N,
  output logic       LOCK_OK,
  output logic       FAIL,
  output logic [3:0] RETRY_CNT
`ifdef LOCK_LOSS_CNT_EN
  ,
  output logic [7:0] LOCK_LOSS_CNT
`endif
);

  localparam int MAX_A = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ? RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_P = (MAX_A > STABLE_CYCLES) ? MAX_A : STABLE_CYCLES;
  localparam int CNT_W = $clog2(MAX_P) + 1;

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  // The WAIT_LOCK cycle that first sees lock is the first good cycle, so STABLE needs one fewer.
  localparam logic [CNT_W-1:0] ST_LAST  = CNT_W'((STABLE_CYCLES > 1) ? STABLE_CYCLES - 2 : 0);
  localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET,
    S_WAIT,
    S_STABLE,
    S_RUN,
    S_FAIL
  } state_t;

  logic             rst_meta_q, rst_sync_q;
  logic             lock_meta_q, lock_sync_q;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic             mmcm_rst_q, sys_rst_n_q, lock_ok_q, fail_q;
  logic             run_lost;

  always_ff @(posedge CLKIN1 or negedge RST_N) begin
    if (!RST_N) begin
      rst_meta_q  <= 1'b0;
      rst_sync_q  <= 1'b0;
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
    end else begin
      rst_meta_q  <= 1'b1;
      rst_sync_q  <= rst_meta_q;
      lock_meta_q <= LOCKED;
      lock_sync_q <= lock_meta_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    retry_d  = retry_q;
    run_lost = 1'b0;
    if (FORCE_RESET) begin
      state_d = S_RESET;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        S_RESET: begin
          if (cnt_q == RST_LAST) begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_WAIT: begin
          if (lock_sync_q) begin
            state_d = S_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TO_LAST) begin
            cnt_d = '0;
            if (retry_q == RETRY_MAX) begin
              state_d = S_FAIL;
            end else begin
              state_d = S_RESET;
              retry_d = retry_q + 4'd1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_STABLE: begin
          if (!lock_sync_q) begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end else if (cnt_q == ST_LAST) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        S_RUN: begin
          if (!lock_sync_q) begin
            state_d  = S_RESET;
            cnt_d    = '0;
            retry_d  = '0;
            run_lost = 1'b1;
          end
        end
        S_FAIL: begin
          state_d = S_FAIL;
        end
        default: begin
          state_d = S_RESET;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs decode the next state so they change on the same edge as the state register.
  always_ff @(posedge CLKIN1 or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_RESET;
      cnt_q       <= '0;
      retry_q     <= '0;
      mmcm_rst_q  <= 1'b1;
      sys_rst_n_q <= 1'b0;
      lock_ok_q   <= 1'b0;
      fail_q      <= 1'b0;
    end else if (rst_sync_q) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      mmcm_rst_q  <= (state_d == S_RESET) || (state_d == S_FAIL);
      sys_rst_n_q <= (state_d == S_RUN);
      lock_ok_q   <= (state_d == S_RUN);
      fail_q      <= (state_d == S_FAIL);
    end
  end

  assign MMCM_RST  = mmcm_rst_q;
  assign SYS_RST_N = sys_rst_n_q;
  assign LOCK_OK   = lock_ok_q;
  assign FAIL      = fail_q;
  assign RETRY_CNT = retry_q;

`ifdef LOCK_LOSS_CNT_EN
  logic [7:0] loss_q;

  always_ff @(posedge CLKIN1 or negedge RST_N) begin
    if (!RST_N) begin
      loss_q <= '0;
    end else if (rst_sync_q && run_lost && (loss_q != 8'hFF)) begin
      loss_q <= loss_q + 8'd1;
    end
  end

  assign LOCK_LOSS_CNT = loss_q;
`else
  logic unused_run_lost;
  assign unused_run_lost = run_lost;
`endif

endmodule
